// File: rtl/debug_pkg.sv
// Shared types and codes for the multi-hart debug controller.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_ABSTRACT,
        ST_STEP
    } hart_state_e;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

endpackage

// File: rtl/d_ctl_mh_if.sv
// Abstract-command bus between the debug module, this controller and the harts.
interface d_ctl_mh_if #(
    parameter int NUM_HARTS = 1,
    parameter int HART_W    = 3
);
    logic                 abs_exec;
    logic [HART_W-1:0]    abs_hart;
    logic [NUM_HARTS-1:0] abs_start;
    logic [NUM_HARTS-1:0] abs_done_in;
    logic [NUM_HARTS-1:0] abs_fault;
    logic                 abs_done;
    logic [2:0]           abs_cmderr;

    modport slave (
        input  abs_exec, abs_hart, abs_done_in, abs_fault,
        output abs_start, abs_done, abs_cmderr
    );

    modport master (
        output abs_exec, abs_hart, abs_done_in, abs_fault,
        input  abs_start, abs_done, abs_cmderr
    );
endinterface

// File: rtl/d_hart_fsm.sv
// Debug-mode state machine for one hart: halt, resume, single-step and abstract-command occupancy.
module d_hart_fsm
    import debug_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       resethalt_req,
    input  logic       halt_req,
    input  logic       resume_req,
    input  logic       ebreak,
    input  logic       step_en,
    input  logic       retire,
    input  logic       quiesced,
    input  logic       exec_sel,
    input  logic       done_in,
    input  logic       fault_in,
    output logic       debug,
    output logic       halted,
    output logic       idle,
    output logic       resume_ack,
    output logic [2:0] cause,
    output logic       cause_we,
    output logic       abs_start,
    output logic       fin,
    output logic       fin_fault
);

    hart_state_e state, state_nxt;
    logic [2:0]  cause_nxt, halt_cause;
    logic        cause_we_nxt, resume_ack_nxt, abs_start_nxt;
    logic        rst_seen, rh_q;

    // rh_q keeps the last resethalt_req seen on a clock edge, so the value
    // sampled during reset is still available in the first cycle after release.
    always_ff @(posedge clk) begin
        rh_q <= resethalt_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            cause      <= CAUSE_NONE;
            cause_we   <= 1'b0;
            resume_ack <= 1'b0;
            abs_start  <= 1'b0;
            rst_seen   <= 1'b1;
        end else begin
            state      <= state_nxt;
            cause      <= cause_nxt;
            cause_we   <= cause_we_nxt;
            resume_ack <= resume_ack_nxt;
            abs_start  <= abs_start_nxt;
            rst_seen   <= 1'b0;
        end
    end

    always_comb begin
        state_nxt      = state;
        cause_nxt      = cause;
        cause_we_nxt   = 1'b0;
        resume_ack_nxt = 1'b0;
        abs_start_nxt  = 1'b0;
        halt_cause     = CAUSE_NONE;
        case (state)
            ST_RUN, ST_STEP: begin
                if (state == ST_RUN && rst_seen && rh_q) halt_cause = CAUSE_RESETHALT;
                else if (ebreak)                         halt_cause = CAUSE_EBREAK;
                else if (halt_req)                       halt_cause = CAUSE_HALTREQ;
                else if (state == ST_STEP && retire)     halt_cause = CAUSE_STEP;
            end
            ST_HALTING: begin
                if (quiesced) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (exec_sel) begin
                    state_nxt     = ST_ABSTRACT;
                    abs_start_nxt = 1'b1;
                end else if (resume_req && !halt_req) begin
                    resume_ack_nxt = 1'b1;
                    state_nxt      = step_en ? ST_STEP : ST_RUN;
                end
            end
            ST_ABSTRACT: begin
                if (done_in) state_nxt = ST_HALTED;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (halt_cause != CAUSE_NONE) begin
            state_nxt    = ST_HALTING;
            cause_nxt    = halt_cause;
            cause_we_nxt = 1'b1;
        end
    end

    // A reset-halt hart is already frozen while reset is held.
    assign debug     = (state == ST_HALTING) || (state == ST_HALTED) || (state == ST_ABSTRACT)
                       || (rst_seen && rh_q);
    assign halted    = (state == ST_HALTED) || (state == ST_ABSTRACT);
    assign idle      = (state == ST_HALTED);
    assign fin       = (state == ST_ABSTRACT) && done_in;
    assign fin_fault = fin && fault_in;

endmodule

// File: rtl/d_ctl_mh.sv
// Multi-hart debug controller: per-hart debug FSMs plus abstract-command dispatch and completion.
module d_ctl_mh
    import debug_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter int HART_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_HARTS-1:0]   halt_req,
    input  logic [NUM_HARTS-1:0]   resume_req,
    input  logic [NUM_HARTS-1:0]   resethalt_req,
    input  logic [NUM_HARTS-1:0]   ebreak,
    input  logic [NUM_HARTS-1:0]   step_en,
    input  logic [NUM_HARTS-1:0]   retire,
    input  logic [NUM_HARTS-1:0]   quiesced,
    output logic [NUM_HARTS-1:0]   debug,
    output logic [NUM_HARTS-1:0]   halted,
    output logic [NUM_HARTS-1:0]   resume_ack,
    output logic [3*NUM_HARTS-1:0] cause,
    output logic [NUM_HARTS-1:0]   cause_we,
    d_ctl_mh_if.slave              abs
);

    logic [NUM_HARTS-1:0] idle, exec_sel, fin, fin_fault, start;
    logic                 hart_ok, done_nxt;
    logic [2:0]           cmderr_nxt;

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        d_hart_fsm u_fsm (
            .clk           (clk),
            .rst           (rst),
            .resethalt_req (resethalt_req[g]),
            .halt_req      (halt_req[g]),
            .resume_req    (resume_req[g]),
            .ebreak        (ebreak[g]),
            .step_en       (step_en[g]),
            .retire        (retire[g]),
            .quiesced      (quiesced[g]),
            .exec_sel      (exec_sel[g]),
            .done_in       (abs.abs_done_in[g]),
            .fault_in      (abs.abs_fault[g]),
            .debug         (debug[g]),
            .halted        (halted[g]),
            .idle          (idle[g]),
            .resume_ack    (resume_ack[g]),
            .cause         (cause[3*g +: 3]),
            .cause_we      (cause_we[g]),
            .abs_start     (start[g]),
            .fin           (fin[g]),
            .fin_fault     (fin_fault[g])
        );
    end

    assign abs.abs_start = start;

    // Completion of a running command takes the response slot; a rejected
    // abs_exec arriving in that same cycle is a debug-module protocol error.
    always_comb begin
        exec_sel   = '0;
        done_nxt   = 1'b0;
        cmderr_nxt = CMDERR_NONE;
        hart_ok    = int'(abs.abs_hart) < NUM_HARTS;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (abs.abs_exec && int'(abs.abs_hart) == h && idle[h]) exec_sel[h] = 1'b1;
        end
        if (|fin) begin
            done_nxt   = 1'b1;
            cmderr_nxt = (|fin_fault) ? CMDERR_EXCEPTION : CMDERR_NONE;
        end else if (abs.abs_exec) begin
            if (!hart_ok) begin
                done_nxt   = 1'b1;
                cmderr_nxt = CMDERR_NOTSUP;
            end else if (exec_sel == '0) begin
                done_nxt   = 1'b1;
                cmderr_nxt = CMDERR_HALTRESUME;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs.abs_done   <= 1'b0;
            abs.abs_cmderr <= CMDERR_NONE;
        end else begin
            abs.abs_done   <= done_nxt;
            abs.abs_cmderr <= cmderr_nxt;
        end
    end

endmodule

// File: tb/tb_d_ctl_mh.sv
// Bench for d_ctl_mh with four harts: halt-cause table, stepping, abstract commands and reset corners.
module tb_d_ctl_mh;

    localparam int NH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NH-1:0] halt_req = '0, resume_req = '0, resethalt_req = '0, ebreak = '0;
    logic [NH-1:0] step_en = '0, retire = '0, quiesced = '0;
    logic [NH-1:0] debug, halted, resume_ack, cause_we;
    logic [3*NH-1:0] cause;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        int         hart;
        logic       eb;
        logic       hr;
        logic [2:0] cause;
    } halt_vec_t;
    halt_vec_t hv[5];

    d_ctl_mh_if #(.NUM_HARTS(NH), .HART_W(3)) ifc ();

    d_ctl_mh #(.NUM_HARTS(NH), .HART_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .halt_req      (halt_req),
        .resume_req    (resume_req),
        .resethalt_req (resethalt_req),
        .ebreak        (ebreak),
        .step_en       (step_en),
        .retire        (retire),
        .quiesced      (quiesced),
        .debug         (debug),
        .halted        (halted),
        .resume_ack    (resume_ack),
        .cause         (cause),
        .cause_we      (cause_we),
        .abs           (ifc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] cause_of(input int h);
        return cause[3*h +: 3];
    endfunction

    // Scoreboard: every abs_done must match the oldest expected cmderr.
    always @(negedge clk) begin
        if (ifc.abs_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL abs_done_unexpected: got done cmderr=%0d want no done", ifc.abs_cmderr);
            end else if (ifc.abs_cmderr !== exp_q[0]) begin
                errors++;
                $display("FAIL sb_cmderr: got %0d want %0d", ifc.abs_cmderr, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        ifc.abs_exec    = 1'b0;
        ifc.abs_hart    = '0;
        ifc.abs_done_in = '0;
        ifc.abs_fault   = '0;

        hv[0] = '{hart: 0, eb: 1'b0, hr: 1'b1, cause: 3'd3};
        hv[1] = '{hart: 1, eb: 1'b1, hr: 1'b0, cause: 3'd1};
        hv[2] = '{hart: 2, eb: 1'b1, hr: 1'b1, cause: 3'd1};
        hv[3] = '{hart: 3, eb: 1'b0, hr: 1'b1, cause: 3'd3};
        hv[4] = '{hart: 2, eb: 1'b0, hr: 1'b1, cause: 3'd3};

        // Reset state
        step(); step(); step();
        chk("rst_debug", debug, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cause", cause, 0);
        chk("rst_cause_we", cause_we, 0);
        chk("rst_resume_ack", resume_ack, 0);
        chk("rst_abs_start", ifc.abs_start, 0);
        chk("rst_abs_done", ifc.abs_done, 0);
        chk("rst_abs_cmderr", ifc.abs_cmderr, 0);
        rst = 1'b0;
        step();

        // Halt-cause table: halt one hart, others must stay out of debug
        for (int i = 0; i < 5; i++) begin
            int h;
            h = hv[i].hart;
            ebreak[h] = hv[i].eb;
            halt_req[h] = hv[i].hr;
            step();
            ebreak = '0;
            halt_req = '0;
            chk($sformatf("tab%0d_cause_we", i), cause_we, 1 << h);
            chk($sformatf("tab%0d_cause", i), cause_of(h), hv[i].cause);
            chk($sformatf("tab%0d_debug", i), debug, 1 << h);
            chk($sformatf("tab%0d_halting", i), halted, 0);
            quiesced[h] = 1'b1;
            step();
            chk($sformatf("tab%0d_halted", i), halted, 1 << h);
            chk($sformatf("tab%0d_we_once", i), cause_we, 0);
            quiesced[h] = 1'b0;
            resume_req[h] = 1'b1;
            step();
            resume_req = '0;
            chk($sformatf("tab%0d_resume_ack", i), resume_ack, 1 << h);
            chk($sformatf("tab%0d_debug_off", i), debug, 0);
            chk($sformatf("tab%0d_cause_hold", i), cause_of(h), hv[i].cause);
            step();
            chk($sformatf("tab%0d_ack_once", i), resume_ack, 0);
        end

        // halt_req on hart0, quiesced arrives after three cycles
        halt_req[0] = 1'b1;
        step();
        chk("h0_cause_we", cause_we[0], 1);
        chk("h0_cause", cause_of(0), 3);
        chk("h0_debug", debug[0], 1);
        chk("h0_c1_halted", halted[0], 0);
        step();
        chk("h0_c2_we", cause_we[0], 0);
        chk("h0_c2_halted", halted[0], 0);
        step();
        chk("h0_c3_halted", halted[0], 0);
        quiesced[0] = 1'b1;
        step();
        quiesced[0] = 1'b0;
        chk("h0_c4_halted", halted[0], 1);
        resume_req[0] = 1'b1;
        step();
        resume_req = '0;
        chk("haltwins_ack", resume_ack[0], 0);
        chk("haltwins_halted", halted[0], 1);
        halt_req[0] = 1'b0;

        // Abstract command on halted hart0 with fault, resume ignored meanwhile
        ifc.abs_exec = 1'b1; ifc.abs_hart = 3'd0;
        step();
        ifc.abs_exec = 1'b0;
        chk("abs_start0", ifc.abs_start, 4'b0001);
        chk("abs_halted", halted[0], 1);
        resume_req[0] = 1'b1;
        step();
        resume_req = '0;
        chk("abs_resume_ignored", resume_ack[0], 0);
        chk("abs_start_once", ifc.abs_start, 0);
        chk("abs_no_early_done", ifc.abs_done, 0);
        ifc.abs_done_in[0] = 1'b1; ifc.abs_fault[0] = 1'b1;
        exp_q.push_back(3'd3);
        step();
        ifc.abs_done_in = '0; ifc.abs_fault = '0;
        chk("abs_fault_done", ifc.abs_done, 1);
        chk("abs_fault_cmderr", ifc.abs_cmderr, 3);
        chk("abs_fault_halted", halted[0], 1);
        ifc.abs_exec = 1'b1; ifc.abs_hart = 3'd0;
        step();
        ifc.abs_exec = 1'b0;
        chk("abs_relaunch", ifc.abs_start, 4'b0001);
        ifc.abs_done_in[0] = 1'b1;
        exp_q.push_back(3'd0);
        step();
        ifc.abs_done_in = '0;
        chk("abs_ok_done", ifc.abs_done, 1);
        chk("abs_ok_cmderr", ifc.abs_cmderr, 0);

        // Rejected commands
        ifc.abs_exec = 1'b1; ifc.abs_hart = 3'd1;
        exp_q.push_back(3'd4);
        step();
        ifc.abs_exec = 1'b0;
        chk("run_done", ifc.abs_done, 1);
        chk("run_cmderr", ifc.abs_cmderr, 4);
        chk("run_no_start", ifc.abs_start, 0);
        chk("run_no_debug", debug[1], 0);
        ifc.abs_exec = 1'b1; ifc.abs_hart = 3'd5;
        exp_q.push_back(3'd2);
        step();
        ifc.abs_exec = 1'b0;
        chk("badhart_done", ifc.abs_done, 1);
        chk("badhart_cmderr", ifc.abs_cmderr, 2);

        // Single step on hart0
        step_en[0] = 1'b1;
        resume_req[0] = 1'b1;
        step();
        resume_req = '0;
        chk("step_ack", resume_ack[0], 1);
        chk("step_debug_off", debug[0], 0);
        step(); step();
        chk("step_waiting", debug[0], 0);
        retire[0] = 1'b1;
        step();
        retire = '0;
        chk("step_we", cause_we[0], 1);
        chk("step_cause", cause_of(0), 4);
        chk("step_debug", debug[0], 1);
        retire[0] = 1'b1;
        step();
        retire = '0;
        chk("step_second_we", cause_we[0], 0);
        chk("step_second_cause", cause_of(0), 4);
        quiesced[0] = 1'b1;
        step();
        quiesced[0] = 1'b0;
        chk("step_halted", halted[0], 1);
        resume_req[0] = 1'b1;
        step();
        resume_req = '0;
        ebreak[0] = 1'b1; retire[0] = 1'b1;
        step();
        ebreak = '0; retire = '0;
        chk("step_eb_cause", cause_of(0), 1);
        chk("step_eb_we", cause_we[0], 1);
        quiesced[0] = 1'b1;
        step();
        quiesced[0] = 1'b0;
        resume_req[0] = 1'b1;
        step();
        resume_req = '0;
        halt_req[0] = 1'b1; retire[0] = 1'b1;
        step();
        halt_req = '0; retire = '0;
        chk("step_hr_cause", cause_of(0), 3);
        quiesced[0] = 1'b1;
        step();
        quiesced[0] = 1'b0;
        step_en = '0;
        chk("step_hr_halted", halted[0], 1);

        // Reset during an abstract command, with reset-halt on hart2
        ifc.abs_exec = 1'b1; ifc.abs_hart = 3'd0;
        step();
        ifc.abs_exec = 1'b0;
        chk("rstabs_start", ifc.abs_start, 4'b0001);
        rst = 1'b1;
        resethalt_req = 4'b0100;
        step(); step();
        chk("rst2_cause0", cause_of(0), 0);
        chk("rst2_cause_we", cause_we, 0);
        chk("rst2_ack", resume_ack, 0);
        chk("rst2_abs_done", ifc.abs_done, 0);
        chk("rst2_debug", debug, 4'b0100);
        rst = 1'b0;
        ifc.abs_done_in[0] = 1'b1;
        step();
        ifc.abs_done_in = '0;
        resethalt_req = '0;
        chk("rh_cause_we", cause_we, 4'b0100);
        chk("rh_cause", cause_of(2), 5);
        chk("rh_debug", debug, 4'b0100);
        chk("rh_no_abs_done", ifc.abs_done, 0);
        quiesced[2] = 1'b1;
        step();
        quiesced = '0;
        chk("rh_halted", halted, 4'b0100);
        step(); step();
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_ctl_mh.md
D_CTL_MH -- requirements
Module: d_ctl_mh

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, meaning the number of independently controlled harts (legal range 1..8).
REQ-002 SHALL have parameter HART_W, default 3, meaning the width of the hart-select field (at least clog2(NUM_HARTS)).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port halt_req, input, NUM_HARTS bits, the level halt request per hart from the debug module.
REQ-006 SHALL have port resume_req, input, NUM_HARTS bits, the one-cycle resume pulse per hart.
REQ-007 SHALL have port resethalt_req, input, NUM_HARTS bits, sampled while rst is high; halts the hart at reset release.
REQ-008 SHALL have port ebreak, input, NUM_HARTS bits, the one-cycle ebreak-into-debug pulse per hart.
REQ-009 SHALL have port step_en, input, NUM_HARTS bits, the DCSR.step bit per hart.
REQ-010 SHALL have port retire, input, NUM_HARTS bits, the one-cycle instruction-retired pulse per hart.
REQ-011 SHALL have port quiesced, input, NUM_HARTS bits, high when the hart pipeline is drained and stalled.
REQ-012 SHALL have port debug, output, NUM_HARTS bits, high when the hart is in debug mode (fetch frozen).
REQ-013 SHALL have port halted, output, NUM_HARTS bits, high in the HALTED or ABSTRACT state.
REQ-014 SHALL have port resume_ack, output, NUM_HARTS bits, a one-cycle pulse on leaving debug mode.
REQ-015 SHALL have port cause, output, 3*NUM_HARTS bits, the DCSR.cause value per hart.
REQ-016 SHALL have port cause_we, output, NUM_HARTS bits, a one-cycle DCSR.cause write strobe per hart.
REQ-017 SHALL have port abs_exec, input, 1 bit, a one-cycle abstract command start pulse.
REQ-018 SHALL have port abs_hart, input, HART_W bits, the hart targeted by abs_exec.
REQ-019 SHALL have port abs_start, output, NUM_HARTS bits, a one-cycle command launch pulse to the selected hart.
REQ-020 SHALL have port abs_done_in, input, NUM_HARTS bits, the command completion pulse from the hart.
REQ-021 SHALL have port abs_fault, input, NUM_HARTS bits, sampled together with abs_done_in; high means exception.
REQ-022 SHALL have port abs_done, output, 1 bit, a one-cycle completion pulse to the debug module.
REQ-023 SHALL have port abs_cmderr, output, 3 bits, the cmderr code valid with abs_done.

Function
REQ-024 SHALL implement one independent five-state FSM per hart with states RUN, HALTING, HALTED, ABSTRACT and STEP.
REQ-025 SHALL, in RUN, go to HALTING on ebreak (cause 1) or halt_req (cause 3); when both occur in the same cycle, cause SHALL be 1.
REQ-026 SHALL assert debug in HALTING, HALTED and ABSTRACT, and SHALL go from HALTING to HALTED in the first cycle quiesced is high.
REQ-027 SHALL pulse cause_we in the cycle of entry to HALTING; cause SHALL hold its value until the next entry.
REQ-028 SHALL, in HALTED, ignore resume_req while halt_req is high (halt wins).
REQ-029 SHALL otherwise, on resume_req in HALTED, pulse resume_ack, deassert debug next cycle, and go to STEP if step_en else RUN.
REQ-030 SHALL, in STEP, go to HALTING with cause 4 on the first retire; halt_req or ebreak SHALL preempt with cause 3 or 1 respectively.
REQ-031 SHALL handle abs_exec as follows: with the target HALTED, pulse abs_start and go to ABSTRACT; in ABSTRACT, abs_done_in returns to HALTED and pulses abs_done with cmderr 0, or 3 if abs_fault.
REQ-032 SHALL, for abs_exec targeting a hart not HALTED, pulse abs_done next cycle with cmderr 4 and change no state.
REQ-033 SHALL, for abs_hart >= NUM_HARTS, pulse abs_done with cmderr 2.
REQ-034 SHALL ignore resume_req in ABSTRACT.
REQ-035 SHALL have latency from request to state change of one cycle, with all outputs registered except debug.

Reset
REQ-036 SHALL, while rst is high, hold every hart in RUN, or in HALTING with cause 5 if resethalt_req is high, with cause_we pulsing on the first cycle after release.
REQ-037 SHALL, during reset, drive resume_ack, abs_start, abs_done and cause_we to 0, abs_cmderr to 0, and cause to 0 for harts in RUN.
REQ-038 SHALL, on reset asserted mid-abstract, abandon the command without emitting abs_done.

Structure
REQ-039 SHALL place the state enum, the cause codes (1/3/4/5) and the cmderr codes (0/2/3/4) in shared package debug_pkg.
REQ-040 SHALL implement one per-hart FSM sub-module, d_hart_fsm, instantiated NUM_HARTS times, with the abstract-command arbitration at top level.

Verification
REQ-041 SHALL cover: halt_req=1 on hart0 in RUN, quiesced after 3 cycles -> cause=3, cause_we pulse, halted=1 at cycle 4.
REQ-042 SHALL cover: ebreak and halt_req in the same cycle -> cause=1.
REQ-043 SHALL cover: step_en=1, resume_req -> resume_ack, one retire -> HALTING with cause=4; no second instruction retires.
REQ-044 SHALL cover: abs_exec to a running hart -> abs_done with cmderr=4; to a halted hart with abs_fault=1 -> cmderr=3, hart stays HALTED.
REQ-045 SHALL cover: NUM_HARTS=4, halt hart2 only -> harts 0, 1 and 3 keep debug=0; abs_hart=5 -> cmderr=2.
REQ-046 SHALL cover: resethalt_req=1 during rst -> halted after release with cause=5; rst asserted in ABSTRACT -> no abs_done.
